als_responder: RTL and testbench

ALS_RESPONDER -- requirements
Module: als_responder

---
 rtl/als_responder.sv | 149 ++++++++++++++
 tb/tb_als_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/als_responder.sv
// Serial ambient-light-sensor responder: shifts one 16-bit frame carrying an
// 8-bit light sample to a reader that drives ncs/scl asynchronously to clk.
module als_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       scl,
    output logic       sda,
    output logic       sda_oe,
    input  logic [7:0] sample_data,
    output logic       frame_done,
    output logic       frame_abort
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [4:0] LAST_RISE  = 5'(FRAME_BITS - 1);
    localparam logic [2:0] FLUSH_DONE = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic                   ncs_hist;
    logic                   scl_hist;
    logic                   ncs_last;
    logic                   scl_last;
    logic [2:0]             flush_cnt;
    logic                   armed;

    logic [1:0] state;
    logic [7:0] shadow;
    logic [3:0] bit_idx;
    logic [3:0] next_idx;
    logic [4:0] rise_cnt;

    logic ncs_fall;
    logic ncs_rise;
    logic scl_fall;
    logic scl_rise;

    // Frame layout: bits 0-2 zero, bits 3-10 carry data MSB first, bits 11-15 zero.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
        if (idx >= 4'd3 && idx <= 4'd10)
            return data[3'(4'd10 - idx)];
        return 1'b0;
    endfunction

    assign ncs_last = ncs_sync[SYNC_STAGES-1];
    assign scl_last = scl_sync[SYNC_STAGES-1];

    assign ncs_fall = armed & ncs_hist & ~ncs_last;
    assign ncs_rise = ~ncs_hist & ncs_last;
    assign scl_fall = scl_hist & ~scl_last;
    assign scl_rise = ~scl_hist & scl_last;

    assign next_idx = (bit_idx == 4'd15) ? 4'd15 : bit_idx + 4'd1;

    // NOTE: every register below is assigned with <= so all state updates
    // see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_sync    <= '1;
            scl_sync    <= '1;
            ncs_hist    <= 1'b1;
            scl_hist    <= 1'b1;
            flush_cnt   <= '0;
            armed       <= 1'b0;
            state       <= ST_IDLE;
            shadow      <= '0;
            bit_idx     <= '0;
            rise_cnt    <= '0;
            sda         <= 1'b0;
            sda_oe      <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            ncs_hist <= ncs_last;
            scl_hist <= scl_last;

            // The reset value of the synchronizer looks like ncs high; a frame may
            // only start once the real pin has been seen high after the flush.
            if (flush_cnt != FLUSH_DONE)
                flush_cnt <= flush_cnt + 3'd1;
            armed <= armed | ((flush_cnt == FLUSH_DONE) & ncs_last);

            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sda    <= 1'b0;
                    sda_oe <= 1'b0;
                    if (ncs_fall) begin
                        shadow   <= sample_data;
                        bit_idx  <= '0;
                        rise_cnt <= '0;
                        sda_oe   <= 1'b1;
                        sda      <= frame_bit(4'd0, sample_data);
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (ncs_rise) begin
                        state       <= ST_IDLE;
                        sda         <= 1'b0;
                        sda_oe      <= 1'b0;
                        frame_abort <= 1'b1;
                    end else begin
                        if (scl_fall) begin
                            bit_idx <= next_idx;
                            sda     <= frame_bit(next_idx, shadow);
                        end
                        if (scl_rise) begin
                            rise_cnt <= rise_cnt + 5'd1;
                            if (rise_cnt == LAST_RISE) begin
                                frame_done <= 1'b1;
                                sda        <= 1'b0;
                                state      <= ST_HOLD;
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    sda    <= 1'b0;
                    sda_oe <= 1'b1;
                    if (ncs_rise) begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    sda    <= 1'b0;
                    sda_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_als_responder.sv
// Self-checking bench for als_responder: a reader model drives ncs/scl, collects
// sda LSB-first into a frame word and compares it against a scoreboard queue.
module tb_als_responder;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ncs;
    logic       scl;
    logic       sda;
    logic       sda_oe;
    logic [7:0] sample_data;
    logic       frame_done;
    logic       frame_abort;

    int n_checks  = 0;
    int n_errors  = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    int rise_tb   = 0;
    int done_rise = -1;

    logic [15:0] exp_q[$];

    als_responder #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ncs         (ncs),
        .scl         (scl),
        .sda         (sda),
        .sda_oe      (sda_oe),
        .sample_data (sample_data),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            done_rise = rise_tb;
        end
        if (frame_abort)
            abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Reader's view of a frame: transmit bit i lands in word bit i.
    function automatic logic [15:0] frame_model(input logic [7:0] d);
        logic [15:0] f;
        f = '0;
        for (int i = 0; i < 8; i++)
            f[3 + i] = d[7 - i];
        return f;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] data, input int n_scl,
                             input int change_at, input logic [7:0] new_data);
        logic [15:0] rd;
        int          d0;
        int          a0;
        rd      = '0;
        d0      = done_cnt;
        a0      = abort_cnt;
        rise_tb = 0;
        sample_data = data;
        if (n_scl >= 16)
            exp_q.push_back(frame_model(data));
        ncs = 1'b0;
        cycles(HALF);
        @(negedge clk);
        check("oe_on", 32'(sda_oe), 32'd1);
        for (int k = 1; k <= n_scl; k++) begin
            @(negedge clk);
            if (k <= 16)
                rd[k-1] = sda;
            else
                check($sformatf("extra_sda_%0d", k), 32'(sda), 32'd0);
            cycles(1);
            scl = 1'b0;
            cycles(HALF);
            scl     = 1'b1;
            rise_tb = k;
            if (k == change_at)
                sample_data = new_data;
            cycles(HALF);
        end
        if (n_scl >= 16) begin
            check("frame_data", 32'(rd), 32'(exp_q.pop_front()));
            check("done_cnt", 32'(done_cnt - d0), 32'd1);
            check("done_at_rise", 32'(done_rise), 32'd16);
        end else begin
            check("no_done", 32'(done_cnt - d0), 32'd0);
        end
        ncs = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        @(negedge clk);
        check("oe_off", 32'(sda_oe), 32'd0);
        check("abort_cnt", 32'(abort_cnt - a0), (n_scl < 16) ? 32'd1 : 32'd0);
        cycles(HALF);
    endtask

    task automatic reset_mid_frame();
        int d0;
        int a0;
        d0          = done_cnt;
        a0          = abort_cnt;
        rise_tb     = 0;
        sample_data = 8'h5A;
        ncs         = 1'b0;
        cycles(HALF);
        for (int k = 1; k <= 16; k++) begin
            scl = 1'b0;
            cycles(HALF);
            scl     = 1'b1;
            rise_tb = k;
            if (k == 9) begin
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
                @(negedge clk);
                check("rst_oe_off", 32'(sda_oe), 32'd0);
            end
            cycles(HALF);
            if (k > 9) begin
                @(negedge clk);
                check($sformatf("rst_no_drive_%0d", k), 32'(sda_oe), 32'd0);
                cycles(1);
            end
        end
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        ncs = 1'b1;
        cycles(2 * HALF);
        check("rst_no_abort", 32'(abort_cnt - a0), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        ncs         = 1'b1;
        scl         = 1'b1;
        sample_data = 8'h00;
        cycles(4);
        @(negedge clk);
        check("rst_sda", 32'(sda), 32'd0);
        check("rst_oe", 32'(sda_oe), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        cycles(1);
        rst = 1'b0;
        cycles(HALF);

        run_frame(8'hA5, 16, 0, 8'h00);
        run_frame(8'h00, 16, 0, 8'h00);
        run_frame(8'hFF, 16, 0, 8'h00);
        run_frame(8'h3C, 6, 0, 8'h00);
        run_frame(8'h3C, 16, 0, 8'h00);
        run_frame(8'h81, 16, 4, 8'h7E);
        run_frame(8'hC3, 20, 0, 8'h00);
        reset_mid_frame();
        run_frame(8'hA5, 16, 0, 8'h00);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
